// File: rtl/conv2_relu_maxpool_gated.sv
// Bias + ReLU + 15-bit saturation + 2x2/stride-2 max pool on conv2 sums.
// Ports: clk, reset(async hi), enable(gate), in_data/in_valid/bias in; out_data/out_valid/frame_done out.
module conv2_relu_maxpool_gated #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [16:0] in_data,
  input  logic        in_valid,
  input  logic [14:0] bias,
  output logic [14:0] out_data,
  output logic        out_valid,
  output logic        frame_done
);

  localparam int CW  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LB  = IMG_W / 2;
  localparam int LBW = (LB > 1) ? $clog2(LB) : 1;

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [14:0]    pair;
  logic [14:0]    linebuf [2**LBW];

  logic [17:0]    s;
  logic [14:0]    r;
  logic [14:0]    h;
  logic [14:0]    lb_q;
  logic [14:0]    pool;
  logic [CW-1:0]  half;
  logic [LBW-1:0] lidx;
  logic           last_col;
  logic           last_row;
  logic           take;

  assign take     = enable & in_valid;
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));
  assign half     = col >> 1;
  assign lidx     = LBW'(half);

  // 18-bit sum cannot overflow; ReLU then clamp anything >= 2^14
  assign s = {in_data[16], in_data} + {{3{bias[14]}}, bias};

  always_comb begin
    r = s[14:0];
    if (s[17])
      r = '0;
    else if (|s[16:14])
      r = 15'h3fff;
  end

  // all operands are non-negative, so unsigned compare is exact
  assign h    = (pair > r) ? pair : r;
  assign lb_q = linebuf[lidx];
  assign pool = (lb_q > h) ? lb_q : h;

  // line buffer holds horizontal maxima of the even row; no reset needed
  always_ff @(posedge clk) begin
    if (take && col[0] && !row[0])
      linebuf[lidx] <= h;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      pair       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (!enable) begin
      col        <= '0;
      row        <= '0;
      pair       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (!col[0]) begin
          pair <= r;
        end else if (row[0]) begin
          out_data   <= pool;
          out_valid  <= 1'b1;
          frame_done <= last_row & last_col;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv2_relu_maxpool_gated.sv
// Randomized self-checking bench for conv2_relu_maxpool_gated.
// Reference model pools whole-frame pixel arrays with plain integer math.
module tb_conv2_relu_maxpool_gated;

  localparam int W = 8;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [16:0] in_data;
  logic        in_valid;
  logic [14:0] bias;
  logic [14:0] out_data;
  logic        out_valid;
  logic        frame_done;

  conv2_relu_maxpool_gated #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .bias       (bias),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int          pix [W*H];
  int          idx;
  int          last_out;
  logic        ev;
  logic        efd;
  logic [14:0] ed;
  int          vectors;
  int          miscompares;

  task automatic model_reset();
    idx = 0;
    last_out = 0;
    ev = 1'b0;
    efd = 1'b0;
    ed = '0;
  endtask

  task automatic model_sample(input int d, input int b);
    int s, rv, rr, cc, m;
    s  = d + b;
    rv = (s < 0) ? 0 : ((s > 16383) ? 16383 : s);
    pix[idx] = rv;
    rr = idx / W;
    cc = idx % W;
    ev = 1'b0;
    efd = 1'b0;
    if ((rr % 2 == 1) && (cc % 2 == 1)) begin
      m = pix[idx];
      if (pix[idx-1] > m) m = pix[idx-1];
      if (pix[idx-W] > m) m = pix[idx-W];
      if (pix[idx-W-1] > m) m = pix[idx-W-1];
      last_out = m;
      ev = 1'b1;
      efd = (idx == W*H-1);
    end
    ed = 15'(last_out);
    idx = (idx + 1) % (W*H);
  endtask

  task automatic send(input int d, input int b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 17'(d);
    bias     = 15'(b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 17'($urandom);
    bias     = 15'($urandom);
    model_sample(d, b);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 17'($urandom);
    @(posedge clk);
    #1;
    ev  = 1'b0;
    efd = 1'b0;
    ed  = 15'(last_out);
  endtask

  function automatic int rnd_d();
    return int'($urandom_range(0, 131071)) - 65536;
  endfunction

  function automatic int rnd_b();
    return int'($urandom_range(0, 32767)) - 16384;
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    bias     = '0;
    #12;
    vectors++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_data !== 15'd0) begin
      miscompares++;
      $display("FAIL reset: v=%b fd=%b d=%0d, want 0 0 0",
               out_valid, frame_done, out_data);
    end
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    model_reset();
  endtask

  task automatic test_constant();
    int nv, nfd;
    nv = 0;
    nfd = 0;
    for (int i = 0; i < W*H; i++) begin
      send(100, 0);
      if (out_valid === 1'b1) nv++;
      if (frame_done === 1'b1) nfd++;
      vectors++;
      if (out_valid !== ev || frame_done !== efd || out_data !== ed) begin
        miscompares++;
        $display("FAIL const px%0d: v=%b fd=%b d=%0d, want v=%b fd=%b d=%0d",
                 i, out_valid, frame_done, out_data, ev, efd, ed);
      end
    end
    vectors++;
    if (nv != 16 || nfd != 1) begin
      miscompares++;
      $display("FAIL const_count: strobes=%0d fd=%0d, want 16 1", nv, nfd);
    end
  endtask

  task automatic test_relu();
    for (int i = 0; i < W*H; i++) begin
      send(-50, 20);
      vectors++;
      if (out_valid !== ev || frame_done !== efd || out_data !== ed) begin
        miscompares++;
        $display("FAIL relu px%0d: v=%b fd=%b d=%0d, want v=%b fd=%b d=%0d",
                 i, out_valid, frame_done, out_data, ev, efd, ed);
      end
    end
  endtask

  task automatic test_saturation();
    int dv [3];
    int bv [3];
    int want [3];
    dv = '{65535, 16000, 16000};
    bv = '{16383, 383, 382};
    want = '{16383, 16383, 16382};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < W*H; i++) begin
        send(dv[k], bv[k]);
        vectors++;
        if (out_valid !== ev || frame_done !== efd || out_data !== ed) begin
          miscompares++;
          $display("FAIL sat%0d px%0d: v=%b d=%0d, want v=%b d=%0d",
                   k, i, out_valid, out_data, ev, ed);
        end
      end
      vectors++;
      if (out_data !== 15'(want[k])) begin
        miscompares++;
        $display("FAIL sat_value%0d: got %0d, want %0d", k, out_data, want[k]);
      end
    end
  endtask

  task automatic test_window();
    int win [4];
    int nz, seen;
    for (int p = 0; p < 4; p++) begin
      for (int j = 0; j < 4; j++) win[j] = (j == p) ? 7 : 1 + 2 * ((j + 3 - p) % 3);
      nz = 0;
      seen = 0;
      for (int i = 0; i < W*H; i++) begin
        int v;
        v = 0;
        if (i == 2*W+4) v = win[0];
        if (i == 2*W+5) v = win[1];
        if (i == 3*W+4) v = win[2];
        if (i == 3*W+5) v = win[3];
        send(v, 0);
        if (out_valid === 1'b1 && out_data !== 15'd0) begin
          nz++;
          seen = int'(out_data);
        end
        vectors++;
        if (out_valid !== ev || frame_done !== efd || out_data !== ed) begin
          miscompares++;
          $display("FAIL win%0d px%0d: v=%b d=%0d, want v=%b d=%0d",
                   p, i, out_valid, out_data, ev, ed);
        end
      end
      vectors++;
      if (nz != 1 || seen != 7) begin
        miscompares++;
        $display("FAIL win%0d_only: nonzero=%0d val=%0d, want 1 7", p, nz, seen);
      end
    end
  endtask

  task automatic test_gating();
    for (int i = 0; i < 20; i++) begin
      send(rnd_d() / 4, rnd_b() / 4);
      vectors++;
      if (out_valid !== ev || out_data !== ed || frame_done !== efd) begin
        miscompares++;
        $display("FAIL pregate px%0d: v=%b d=%0d, want v=%b d=%0d",
                 i, out_valid, out_data, ev, ed);
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      enable   = 1'b0;
      in_valid = 1'b1;
      in_data  = 17'(1000 + c);
      bias     = 15'd5;
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_data !== 15'd0) begin
        miscompares++;
        $display("FAIL gated c%0d: v=%b fd=%b d=%0d, want 0 0 0",
                 c, out_valid, frame_done, out_data);
      end
    end
    model_reset();
    @(negedge clk);
    in_valid = 1'b0;
    enable   = 1'b1;
    for (int i = 0; i < W*H; i++) begin
      send(rnd_d() / 4, rnd_b() / 4);
      vectors++;
      if (out_valid !== ev || frame_done !== efd || out_data !== ed) begin
        miscompares++;
        $display("FAIL postgate px%0d: v=%b fd=%b d=%0d, want v=%b fd=%b d=%0d",
                 i, out_valid, frame_done, out_data, ev, efd, ed);
      end
    end
  endtask

  task automatic test_gaps_reset();
    for (int i = 0; i < 37 + W*H; i++) begin
      int g;
      g = int'($urandom_range(0, 3));
      for (int k = 0; k < g; k++) begin
        idle();
        vectors++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_data !== ed) begin
          miscompares++;
          $display("FAIL gap px%0d: v=%b fd=%b d=%0d, want 0 0 %0d",
                   i, out_valid, frame_done, out_data, ed);
        end
      end
      send(rnd_d() / 4, rnd_b() / 4);
      vectors++;
      if (out_valid !== ev || frame_done !== efd || out_data !== ed) begin
        miscompares++;
        $display("FAIL gaps px%0d: v=%b fd=%b d=%0d, want v=%b fd=%b d=%0d",
                 i, out_valid, frame_done, out_data, ev, efd, ed);
      end
      if (i == 36) begin
        #1 reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_data !== 15'd0) begin
          miscompares++;
          $display("FAIL async_reset: v=%b fd=%b d=%0d, want 0 0 0",
                   out_valid, frame_done, out_data);
        end
        #1 reset = 1'b0;
        model_reset();
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_reset();
    test_reset();
    test_constant();
    test_relu();
    test_saturation();
    test_window();
    test_gating();
    test_gaps_reset();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
